// File: rtl/rf_writeback_queue_if.sv
// Producer-side handshake bundle for rf_writeback_queue.
// Carries one offered writeback result per cycle into the queue.
//   in_valid  producer offers a result
//   in_ready  queue can accept this cycle
//   in_reg    destination register index of the offered result
//   in_data   result data
// master = producer (execute/memory stage), slave = the queue.
interface rf_writeback_queue_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;

    modport master (
        output in_valid,
        output in_reg,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_reg,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// Write-side initiator for the register file. Buffers writeback results in an
// in-order FIFO and drains one per cycle onto the register file write port.
// Also publishes a per-register pending bitmap so decode can stall reads of
// destinations that still have a queued write.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   push      producer handshake (in_valid/in_ready/in_reg/in_data), slave side
//   wb_hold   1: do not drain this cycle (write port borrowed elsewhere)
//   flush     synchronous clear; queued entries are dropped unwritten
//   DstReg    register file write index
//   WriteReg  register file write enable
//   DstData   register file write data
//   pending   bit r set while a queued entry targets register r
//   count     queue occupancy, 0..DEPTH
module rf_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DW         = 16,
    parameter int AW         = 4,
    parameter int DISCARD_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    rf_writeback_queue_if.slave        push,
    input  logic                       wb_hold,
    input  logic                       flush,
    output logic [AW-1:0]              DstReg,
    output logic                       WriteReg,
    output logic [DW-1:0]              DstData,
    output logic [(2**AW)-1:0]         pending,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Storage is deliberately not reset; every output derived from it is
    // gated by occupancy, so stale contents are never visible.
    logic [AW-1:0] reg_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic          push_en;
    logic          drain;
    logic          head_is_r0;
    logic [AW-1:0] head_reg;
    logic [DW-1:0] head_data;

    assign push.in_ready = (count_q < CW'(DEPTH));
    // No pass-through: a full queue refuses even when the head pops this cycle.
    assign push_en       = push.in_valid & push.in_ready & ~flush;
    assign drain         = (count_q != '0) & ~wb_hold & ~flush;

    assign head_reg   = reg_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign head_is_r0 = (DISCARD_R0 != 0) && (head_reg == '0);

    // An R0 entry still pops; it just never raises the write enable.
    assign WriteReg = drain & ~head_is_r0;
    assign DstReg   = drain ? head_reg  : '0;
    assign DstData  = drain ? head_data : '0;
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (push_en) begin
            reg_mem[wr_ptr]  <= push.in_reg;
            data_mem[wr_ptr] <= push.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (drain) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_en, drain})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Pending bitmap from registered state only: the head being popped this
    // cycle is still reported, so decode cannot read ahead of the write.
    logic [PW-1:0]      scan_idx;
    logic [(2**AW)-1:0] pend_c;

    always_comb begin
        pend_c   = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PW'(i);
            if (CW'(i) < count_q) begin
                pend_c[reg_mem[scan_idx]] = 1'b1;
            end
        end
        if (DISCARD_R0 != 0) begin
            pend_c[0] = 1'b0;
        end
    end

    assign pending = pend_c;
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue (DEPTH=4, DW=16, AW=4, DISCARD_R0=1).
// A small register-file model captures the write port on each rising edge.
module tb_rf_writeback_queue;
    logic        clk;
    logic        rst;
    logic        wb_hold;
    logic        flush;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] pending;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    logic [15:0] rf [16];

    rf_writeback_queue_if #(.AW(4), .DW(16)) push_if ();

    rf_writeback_queue #(
        .DEPTH(4), .DW(16), .AW(4), .DISCARD_R0(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push_if),
        .wb_hold  (wb_hold),
        .flush    (flush),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .pending  (pending),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (WriteReg) rf[DstReg] <= DstData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] r, input logic [15:0] d);
        push_if.in_valid = 1'b1;
        push_if.in_reg   = r;
        push_if.in_data  = d;
        tick();
        push_if.in_valid = 1'b0;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        rst              = 1'b0;
        wb_hold          = 1'b0;
        flush            = 1'b0;
        push_if.in_valid = 1'b0;
        push_if.in_reg   = 4'd0;
        push_if.in_data  = 16'h0000;

        // 1: reset then idle
        tick();
        tick();
        check("rst_writereg", 32'(WriteReg), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(push_if.in_ready), 32'd1);
        check("rst_pending", 32'(pending), 32'h0);
        rst = 1'b1;
        tick();
        tick();
        check("idle_writereg", 32'(WriteReg), 32'd0);
        check("idle_count", 32'(count), 32'd0);
        check("idle_in_ready", 32'(push_if.in_ready), 32'd1);
        check("idle_dstreg", 32'(DstReg), 32'd0);

        // 2: single write, one-edge latency
        push_one(4'd3, 16'hBEEF);
        #1;
        check("single_count", 32'(count), 32'd1);
        check("single_writereg", 32'(WriteReg), 32'd1);
        check("single_dstreg", 32'(DstReg), 32'd3);
        check("single_dstdata", 32'(DstData), 32'hBEEF);
        check("single_pending", 32'(pending), 32'h0008);
        tick();
        check("single_after_count", 32'(count), 32'd0);
        check("single_after_pending", 32'(pending), 32'h0);
        check("single_after_writereg", 32'(WriteReg), 32'd0);
        check("single_rf3", 32'(rf[3]), 32'hBEEF);

        // 3: fill under hold, refuse 5th, drain in order
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push_one(4'(i), 16'(16'h1111 * i));
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(push_if.in_ready), 32'd0);
        check("full_pending", 32'(pending), 32'h001E);
        check("full_hold_writereg", 32'(WriteReg), 32'd0);
        push_one(4'd9, 16'h9999);
        #1;
        check("refused_count", 32'(count), 32'd4);
        check("refused_pending", 32'(pending), 32'h001E);
        wb_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_writereg", 32'(WriteReg), 32'd1);
            check("drain_dstreg", 32'(DstReg), 32'(i));
            check("drain_dstdata", 32'(DstData), 32'(16'h1111 * i));
            tick();
        end
        check("drain_done_count", 32'(count), 32'd0);
        check("drain_rf1", 32'(rf[1]), 32'h1111);
        check("drain_rf4", 32'(rf[4]), 32'h4444);
        check("drain_rf9", 32'(rf[9]), 32'h0000);

        // 4: same-register ordering
        wb_hold = 1'b1;
        push_one(4'd5, 16'h0001);
        push_one(4'd5, 16'h0002);
        wb_hold = 1'b0;
        #1;
        check("same_first_data", 32'(DstData), 32'h0001);
        check("same_first_pending", 32'(pending), 32'h0020);
        tick();
        check("same_second_writereg", 32'(WriteReg), 32'd1);
        check("same_second_data", 32'(DstData), 32'h0002);
        check("same_second_pending", 32'(pending), 32'h0020);
        tick();
        check("same_done_pending", 32'(pending), 32'h0);
        check("same_rf5", 32'(rf[5]), 32'h0002);

        // 5: R0 discard
        wb_hold = 1'b1;
        push_one(4'd0, 16'hFFFF);
        push_one(4'd2, 16'h1234);
        #1;
        check("r0_pending", 32'(pending), 32'h0004);
        wb_hold = 1'b0;
        #1;
        check("r0_writereg", 32'(WriteReg), 32'd0);
        tick();
        check("r0_next_count", 32'(count), 32'd1);
        check("r0_next_writereg", 32'(WriteReg), 32'd1);
        check("r0_next_dstreg", 32'(DstReg), 32'd2);
        check("r0_next_dstdata", 32'(DstData), 32'h1234);
        tick();
        check("r0_rf0", 32'(rf[0]), 32'h0000);
        check("r0_rf2", 32'(rf[2]), 32'h1234);

        // 6a: flush mid-drain
        wb_hold = 1'b1;
        push_one(4'd6, 16'h000A);
        push_one(4'd7, 16'h000B);
        push_one(4'd8, 16'h000C);
        wb_hold = 1'b0;
        #1;
        check("pre_flush_dstreg", 32'(DstReg), 32'd6);
        tick();
        check("pre_flush_count", 32'(count), 32'd2);
        flush            = 1'b1;
        push_if.in_valid = 1'b1;
        push_if.in_reg   = 4'd9;
        push_if.in_data  = 16'h5555;
        #1;
        check("flush_writereg", 32'(WriteReg), 32'd0);
        check("flush_dstreg", 32'(DstReg), 32'd0);
        tick();
        flush            = 1'b0;
        push_if.in_valid = 1'b0;
        #1;
        check("post_flush_count", 32'(count), 32'd0);
        check("post_flush_pending", 32'(pending), 32'h0);
        check("post_flush_writereg", 32'(WriteReg), 32'd0);
        tick();
        check("flush_rf6", 32'(rf[6]), 32'h000A);
        check("flush_rf7", 32'(rf[7]), 32'h0000);
        check("flush_rf8", 32'(rf[8]), 32'h0000);

        // 6b: reset mid-drain
        wb_hold = 1'b1;
        push_one(4'd10, 16'h00AA);
        push_one(4'd11, 16'h00BB);
        push_one(4'd12, 16'h00CC);
        wb_hold = 1'b0;
        #1;
        check("pre_rst_writereg", 32'(WriteReg), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_writereg", 32'(WriteReg), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_pending", 32'(pending), 32'h0);
        check("async_rst_in_ready", 32'(push_if.in_ready), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_writereg", 32'(WriteReg), 32'd0);
        check("post_rst_rf11", 32'(rf[11]), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
